// File: rtl/gf2_solver_pkg.sv
// Shared definitions for the GF(2) Gauss-Jordan solver: state encoding, row width
// and the flat-matrix index helper.
package gf2_solver_pkg;

    localparam int DEF_N = 4;
    localparam int ROW_W = DEF_N + 1;

    typedef enum logic [2:0] {
        IDLE,
        PIVOT,
        ELIM,
        DONE,
        CHECK
    } state_t;

    // Bit position of A_c_r inside a column-major flattened matrix.
    function automatic int a_idx(input int c, input int r, input int n);
        return c * n + r;
    endfunction

endpackage

// File: rtl/gf2_pivot_select.sv
// Combinational pivot finder: lowest-index row p >= k whose column-k bit is set.
module gf2_pivot_select #(
    parameter int N = 4,
    localparam int KW = $clog2(N)
) (
    input  logic [N-1:0]  col,
    input  logic [KW-1:0] k,
    output logic [KW-1:0] p,
    output logic          found
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        p     = '0;
        found = 1'b0;
        // Scanning downward lets the lowest qualifying row win.
        for (int r = N - 1; r >= 0; r--) begin
            if (col[r] && (r >= int'(k))) begin
                p     = KW'(r);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gf2_linear_solver.sv
// Sequential Gauss-Jordan solver for A*v = u over GF(2) with valid/ready on both sides.
// Optional build macro GF2_SOLVER_CHECK_EN adds a one-cycle A*v == u self-check.
module gf2_linear_solver
    import gf2_solver_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*N-1:0] a_flat,
    input  logic [N-1:0]   u_flat,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   v_flat,
    output logic           singular,
    output logic           check_fail
);

    localparam int RW = N + 1;
    localparam int KW = $clog2(N);
    localparam int IW = $clog2(RW);

    state_t        state;
    logic [RW-1:0] rows [N];
    logic [KW-1:0] k;
    logic [N-1:0]  v_reg;
    logic          sing_reg;
    logic          out_valid_reg;
    logic          in_ready_reg;

    logic [IW-1:0] k_bit;
    logic [N-1:0]  col_k;
    logic [KW-1:0] piv;
    logic          piv_found;
    logic [RW-1:0] load_rows [N];
    logic [RW-1:0] elim_rows [N];
    logic [N-1:0]  elim_v;
    logic          accept;

    assign accept = (state == IDLE) && in_valid && in_ready_reg;
    assign k_bit  = IW'(k);

    always_comb begin
        for (int r = 0; r < N; r++) begin
            col_k[r]     = rows[r][k_bit];
            load_rows[r] = '0;
            for (int c = 0; c < N; c++) begin
                load_rows[r][c] = a_flat[a_idx(c, r, N)];
            end
            load_rows[r][N] = u_flat[r];
        end
    end

    gf2_pivot_select #(.N(N)) u_pivot (
        .col   (col_k),
        .k     (k),
        .p     (piv),
        .found (piv_found)
    );

    // All rows read pre-update values; once column N-1 is cleared, row c's RHS bit is v_c.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            elim_rows[r] = rows[r];
            if ((r != int'(k)) && rows[r][k_bit]) begin
                elim_rows[r] = rows[r] ^ rows[k];
            end
            elim_v[r] = elim_rows[r][N];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            k             <= '0;
            v_reg         <= '0;
            sing_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
            // NOTE: the row file is small flops, not RAM, so clearing it on reset is cheap and keeps aborts clean.
            for (int r = 0; r < N; r++) begin
                rows[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every row swap/XOR sees the pre-edge values.
            case (state)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        for (int r = 0; r < N; r++) begin
                            rows[r] <= load_rows[r];
                        end
                        k            <= '0;
                        v_reg        <= '0;
                        sing_reg     <= 1'b0;
                        in_ready_reg <= 1'b0;
                        state        <= PIVOT;
                    end
                end
                PIVOT: begin
                    if (piv_found) begin
                        for (int r = 0; r < N; r++) begin
                            if (r == int'(k)) begin
                                rows[r] <= rows[piv];
                            end else if (r == int'(piv)) begin
                                rows[r] <= rows[k];
                            end
                        end
                        state <= ELIM;
                    end else begin
                        sing_reg      <= 1'b1;
                        v_reg         <= '0;
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                ELIM: begin
                    for (int r = 0; r < N; r++) begin
                        rows[r] <= elim_rows[r];
                    end
                    if (k == KW'(N - 1)) begin
                        v_reg <= elim_v;
`ifdef GF2_SOLVER_CHECK_EN
                        state <= CHECK;
`else
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
`endif
                    end else begin
                        k     <= k + 1'b1;
                        state <= PIVOT;
                    end
                end
                CHECK: begin
                    out_valid_reg <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GF2_SOLVER_CHECK_EN
    logic [N*N-1:0] a_copy;
    logic [N-1:0]   u_copy;
    logic [N-1:0]   recomputed;
    logic           check_reg;

    // A*v is the XOR of the columns of A selected by the set bits of v.
    always_comb begin
        recomputed = '0;
        for (int c = 0; c < N; c++) begin
            if (v_reg[c]) begin
                recomputed = recomputed ^ a_copy[c*N +: N];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_copy    <= '0;
            u_copy    <= '0;
            check_reg <= 1'b0;
        end else if (accept) begin
            a_copy    <= a_flat;
            u_copy    <= u_flat;
            check_reg <= 1'b0;
        end else if (state == CHECK) begin
            check_reg <= (recomputed != u_copy);
        end
    end

    assign check_fail = check_reg;
`else
    assign check_fail = 1'b0;
`endif

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign v_flat    = v_reg;
    assign singular  = sing_reg;

endmodule

// File: tb/tb_gf2_linear_solver.sv
// Self-checking bench for gf2_linear_solver: directed cases plus random problems
// scored against a brute-force GF(2) model; honours GF2_SOLVER_CHECK_EN if defined.
module tb_gf2_linear_solver;

    localparam int N = 4;
`ifdef GF2_SOLVER_CHECK_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*N-1:0] a_flat = '0;
    logic [N-1:0]   u_flat = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N-1:0]   v_flat;
    logic           singular;
    logic           check_fail;

    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    logic [3:0] a_flat2 = '0;
    logic [1:0] u_flat2 = '0;
    logic       out_valid2;
    logic       out_ready2 = 1'b0;
    logic [1:0] v_flat2;
    logic       singular2;
    logic       check_fail2;

    int       n_tests = 0;
    int       n_fail = 0;
    logic [N-1:0] exp_v = '0;
    logic     exp_sing = 1'b0;
    logic     exp_chk = 1'b0;
    bit       mon_en = 1'b1;

    always #5 clk = ~clk;

    gf2_linear_solver #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_flat(a_flat), .u_flat(u_flat), .out_valid(out_valid), .out_ready(out_ready),
        .v_flat(v_flat), .singular(singular), .check_fail(check_fail)
    );

    gf2_linear_solver #(.N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_flat(a_flat2), .u_flat(u_flat2), .out_valid(out_valid2), .out_ready(out_ready2),
        .v_flat(v_flat2), .singular(singular2), .check_fail(check_fail2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model: A*v as XOR of selected columns, brute force over all v ----
    function automatic logic [N-1:0] mat_vec(input logic [N*N-1:0] a, input logic [N-1:0] v);
        logic [N-1:0] acc = '0;
        for (int c = 0; c < N; c++) if (v[c]) acc ^= a[c*N +: N];
        return acc;
    endfunction

    // First column that lies in the span of the earlier ones (N when A is invertible).
    function automatic int dep_col(input logic [N*N-1:0] a);
        for (int c = 0; c < N; c++) begin
            for (int s = 0; s < (1 << c); s++) begin
                if (mat_vec(a, N'(s)) == a[c*N +: N]) return c;
            end
        end
        return N;
    endfunction

    function automatic logic [N-1:0] solve_v(input logic [N*N-1:0] a, input logic [N-1:0] u);
        for (int s = 0; s < (1 << N); s++) if (mat_vec(a, N'(s)) == u) return N'(s);
        return '0;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && mon_en) begin
            check("v_flat", 32'(v_flat), 32'(exp_v));
            check("singular", 32'(singular), 32'(exp_sing));
            check("check_fail", 32'(check_fail), 32'(exp_chk));
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
    endtask

    task automatic run_problem(input logic [N*N-1:0] a, input logic [N-1:0] u,
                               input int hold, input bit poke);
        int dep;
        int lat;
        int exp_lat;
        dep = dep_col(a);
        if (dep < N) begin
            exp_sing = 1'b1;
            exp_v    = '0;
            exp_lat  = 2 * dep + 1;
        end else begin
            exp_sing = 1'b0;
            exp_v    = solve_v(a, u);
            exp_lat  = 2 * N + EXTRA;
        end
        exp_chk = 1'b0;
        wait_ready();
        a_flat   = a;
        u_flat   = u;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_flat   = N*N'($urandom);
        u_flat   = N'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 1) in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("in_ready_low_while_done", 32'(in_ready), 32'd0);
            check("out_valid_held", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N*N-1:0] a;
        logic [N-1:0]   u;
        int lat2;

        // model pinned to hand-computed values
        check("model_mat_vec", 32'(mat_vec(16'h8421, 4'b0101)), 32'h5);
        check("model_identity", 32'(solve_v(16'h8421, 4'b1010)), 32'ha);
        check("model_dep_col_singular", 32'(dep_col(16'h8021)), 32'd2);
        check("model_dep_col_identity", 32'(dep_col(16'h8421)), 32'd4);

        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_v_flat", 32'(v_flat), 32'd0);
        check("reset_singular", 32'(singular), 32'd0);
        check("reset_check_fail", 32'(check_fail), 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // N=2 pivot swap: column0=(0,1), column1=(1,1), u=(1,0) -> v=(1,1)
        a_flat2 = 4'b1110;
        u_flat2 = 2'b01;
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat2 = 0;
        while (!out_valid2 && lat2 < 20) begin
            @(posedge clk); #1;
            lat2++;
        end
        check("n2_latency", 32'(lat2), 32'(4 + EXTRA));
        check("n2_v_flat", 32'(v_flat2), 32'h3);
        check("n2_singular", 32'(singular2), 32'd0);
        check("n2_check_fail", 32'(check_fail2), 32'd0);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;

        // identity, then singular (column 2 zero) under 10 cycles of backpressure
        run_problem(16'h8421, 4'b1010, 2, 1'b0);
        run_problem(16'h8021, 4'b0110, 10, 1'b1);

        // reset during ELIM for k=1, then a fresh identity problem
        wait_ready();
        a_flat = 16'h8421;
        u_flat = 4'b0110;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_v_flat", 32'(v_flat), 32'd0);
        check("abort_singular", 32'(singular), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_check_fail", 32'(check_fail), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        run_problem(16'h8421, 4'b1010, 0, 1'b0);

        // randomized problems; even iterations forced invertible
        for (int i = 0; i < 40; i++) begin
            a = N*N'($urandom);
            if (i % 2 == 0) begin
                for (int t = 0; t < 100 && dep_col(a) != N; t++) a = N*N'($urandom);
            end
            u = N'($urandom);
            run_problem(a, u, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

`ifdef GF2_SOLVER_CHECK_EN
        // consistent problem, then the same with v corrupted inside the CHECK cycle
        a = 16'h8421;
        for (int t = 0; t < 100 && dep_col(a) != N; t++) a = N*N'($urandom);
        a = N*N'($urandom);
        for (int t = 0; t < 100 && dep_col(a) != N; t++) a = N*N'($urandom);
        u = mat_vec(a, 4'b1011);
        run_problem(a, u, 1, 1'b0);
        mon_en = 1'b0;
        wait_ready();
        a_flat = a;
        u_flat = u;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2 * N) @(posedge clk);
        #1;
        force dut.v_reg = 4'b1011 ^ 4'b0001;
        @(posedge clk); #1;
        release dut.v_reg;
        check("forced_out_valid", 32'(out_valid), 32'd1);
        check("forced_check_fail", 32'(check_fail), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        mon_en = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gf2_linear_solver.md
Name: gf2_linear_solver

Overview:
- Solves A·v = u for v over GF(2), where multiply is AND and add is XOR. This is the inverse direction of the team's combinational matrix-vector multiplier.
- Inputs are an N×N binary matrix A and a result vector u.
- Method is sequential Gauss-Jordan elimination on an N×(N+1) augmented register file.
- Sits downstream of the multiplier for decode/recovery paths, with a valid/ready handshake on both sides.

Parameters:
- N, 4, matrix dimension (N ≥ 2).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A and u valid.
- in_ready  output  1  solver can accept a problem.
- a_flat  input  N*N  matrix; a_flat[c*N + r] = A_c_r (column c, row r). Row r satisfies u_r = XOR over c of (A_c_r & v_c).
- u_flat  input  N  right-hand side; u_flat[r] = u_r.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- v_flat  output  N  solution; v_flat[c] = v_c.
- singular  output  1  A is not invertible; v_flat is forced to 0.
- check_fail  output  1  self-check mismatch (see Optional Feature).

Behaviour:
- Reset values: in_ready=0 while rst_n low, then 1 once in IDLE. out_valid=0, v_flat=0, singular=0, check_fail=0. Augmented rows and column counter k are cleared. State is IDLE.
- Assertion of rst_n low at any time, including mid-solve, aborts immediately to these values. No partial result is ever emitted.
- States: IDLE, PIVOT, ELIM, DONE; plus CHECK when the optional feature is enabled.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, load augmented row r: bits[c]=A_c_r, bit[N]=u_r. Set k=0 and go to PIVOT.
  - a_flat and u_flat are sampled only on this edge.
- PIVOT (1 cycle):
  - Select the lowest-index row p ≥ k with row[p][k]=1.
  - If found: swap rows p and k (no-op if p=k) and go to ELIM.
  - If none: set singular=1, v_flat=0, go to DONE.
- ELIM (1 cycle):
  - Every row r ≠ k with row[r][k]=1 gets row[r] ^= row[k]. All rows update in parallel, using pre-update values.
  - If k=N-1: v_flat[c] = row[c][N], go to DONE. Otherwise k++ and go to PIVOT.
- DONE:
  - out_valid=1. Outputs are held stable until out_ready.
  - On out_valid && out_ready: out_valid falls next cycle and state returns to IDLE.
  - in_ready=0 in every state except IDLE; there is no overlap of consecutive problems.
- Latency: out_valid rises exactly 2N cycles after the accept edge for an invertible A (8 for N=4).
  - Singular A: out_valid rises 2k+1 cycles after accept, where k is the failing column.
- singular and v_flat are valid only while out_valid=1. They are cleared when a new problem is accepted.
- All arithmetic is bitwise. There is no carry, and widths never grow.

Optional Feature:
- Macro: GF2_SOLVER_CHECK_EN.
- When defined:
  - A copy of the original A and u is kept from accept.
  - After the final ELIM, a CHECK state (1 cycle) recomputes A·v_flat and compares it with the stored u.
  - check_fail=1 on mismatch. It is held with out_valid.
  - Invertible latency becomes 2N+1.
  - CHECK is skipped when singular=1.
- When not defined: check_fail is tied to 0, no copy registers are built, and latency is 2N.

Decomposition:
- Package gf2_solver_pkg holds:
  - the state encoding (IDLE, PIVOT, ELIM, DONE, CHECK);
  - localparam ROW_W = N+1;
  - an index function for a_flat[c*N+r].
- One sub-module, gf2_pivot_select (N parameter, combinational): takes column k of all rows plus k, and returns pivot index p and a found flag. It is a lowest-index priority encoder masked to rows ≥ k.

Test Plan:
- Identity: N=4, A=I, u=4'b1010 -> v_flat=4'b1010, singular=0, out_valid exactly 8 cycles after accept.
- Pivot swap: N=2, A_0_0=0, A_1_0=1, A_0_1=1, A_1_1=1, u=(u_0=1, u_1=0) -> v_0=1, v_1=1, singular=0. This needs a row swap at k=0.
- Singular: N=4, all-zero column 2 (A_2_r=0 for all r), u=4'b0110 -> singular=1, v_flat=0, out_valid after 2·2+1=5 cycles.
- Backpressure: out_ready held low for 10 cycles after out_valid -> v_flat and singular stable, and in_ready=0 throughout. The in_valid pulse during this window is ignored.
- Reset mid-solve: assert rst_n low during ELIM for k=1 -> all outputs are 0 immediately. After release, a fresh identity problem solves correctly.
- With GF2_SOLVER_CHECK_EN: random invertible A with u computed as A·v -> check_fail=0 and latency 9. Forcing a bit flip in v_flat via bench force -> check_fail=1.
